// File: rtl/isa_mem_pkg.sv
// Shared types and constants for the pixel-window cache fill path.
package isa_mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WR, DONE} loader_state_t;
  typedef enum logic {FULL, REFILL} load_mode_t;

  localparam int CACHE_ROWS  = 3;
  localparam int CACHE_COLS  = 4;
  localparam int CACHE_DEPTH = 16;
  localparam int REFILL_COL0 = 2;
endpackage

// File: rtl/image_cache_loader_if.sv
// Control, image-memory read and cache-write signals of the window loader.
interface image_cache_loader_if #(
  parameter int BUS    = 24,
  parameter int ADDR_W = 16
);
  logic              start;
  logic              refill;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] row_stride;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [BUS-1:0]    mem_rdata;
  logic              cache_we;
  logic [4:0]        cache_pos;
  logic [BUS-1:0]    cache_din;
  logic              busy;
  logic              done;

  modport master (
    input  start, refill, base_addr, row_stride, mem_ack, mem_rdata,
    output mem_req, mem_addr, cache_we, cache_pos, cache_din, busy, done
  );
  modport slave (
    output start, refill, base_addr, row_stride, mem_ack, mem_rdata,
    input  mem_req, mem_addr, cache_we, cache_pos, cache_din, busy, done
  );
endinterface

// File: rtl/image_cache_loader.sv
// Fill engine: walks a ROWS x COLS pixel window row-major, one read and one
// cache write per pixel; REFILL mode only reloads the rightmost two columns.
module image_cache_loader
  import isa_mem_pkg::*;
#(
  parameter int BUS    = 24,
  parameter int ADDR_W = 16
) (
  input  logic clk,
  input  logic rst,
  image_cache_loader_if.master bus
);
  loader_state_t     state, state_n;
  load_mode_t        mode;
  logic [2:0]        col;
  logic [1:0]        row;
  logic [4:0]        row_pos;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] stride;
  logic [4:0]        pos_q;
  logic [BUS-1:0]    din_q;
  logic [2:0]        col0;
  logic              last_col;
  logic              last_pix;

  assign col0     = (mode == REFILL) ? 3'(REFILL_COL0) : 3'd0;
  assign last_col = (col == 3'(CACHE_COLS - 1));
  assign last_pix = last_col && (row == 2'(CACHE_ROWS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.start)   state_n = REQ;
      REQ:     if (bus.mem_ack) state_n = WR;
      WR:      state_n = last_pix ? DONE : REQ;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Position/address generator: row_base and row_pos advance by addition only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode     <= FULL;
      col      <= '0;
      row      <= '0;
      row_pos  <= '0;
      row_base <= '0;
      stride   <= '0;
      pos_q    <= '0;
      din_q    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mode     <= bus.refill ? REFILL : FULL;
          col      <= bus.refill ? 3'(REFILL_COL0) : 3'd0;
          row      <= '0;
          row_pos  <= '0;
          row_base <= bus.base_addr;
          stride   <= bus.row_stride;
        end
        REQ: if (bus.mem_ack) begin
          din_q <= bus.mem_rdata;
          pos_q <= row_pos + 5'(col);
        end
        WR: if (last_col) begin
          col      <= col0;
          row      <= row + 2'd1;
          row_pos  <= row_pos + 5'(CACHE_COLS);
          row_base <= row_base + stride;
        end else begin
          col <= col + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = (state == REQ);
  assign bus.mem_addr  = (state == REQ) ? row_base + ADDR_W'(col) : '0;
  assign bus.cache_we  = (state == WR);
  assign bus.cache_pos = pos_q;
  assign bus.cache_din = din_q;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
endmodule
